chrono_counter: RTL and testbench
=================================

# chrono_counter

Parametrised BCD chronometer core for the stopwatch datapath. Divides `CLK` down to a count tick and runs a cascaded mixed-radix BCD counter of 4–6 digits, counting up or down. It supports start/stop, clear, preload and countdown-complete signalling. The 7-segment display driver and button debouncers consume its outputs and drive its inputs.

## Interface
- `TICK_DIV`, 500000: `CLK` cycles per count tick (≥2).
- `NUM_DIGITS`, 4: number of BCD digits (4–6).
- `CLK` input, 1: system clock, rising-edge.
- `RST` input, 1: reset, asynchronous, active-high.
- `start_stop` input, 1: one-cycle pulse that toggles the run state.
- `clear` input, 1: one-cycle pulse that zeroes the digits and stops the counter.
- `load` input, 1: one-cycle pulse that loads `load_bcd` into the digits.
- `load_bcd` input, 4*NUM_DIGITS: preload value, digit 0 in bits [3:0].
- `mode` input, 1: count direction; 0 = up, 1 = down. Sampled only when a start is accepted.
- `time_bcd` output, 4*NUM_DIGITS: current digits, digit 0 in bits [3:0].
- `running` output, 1: high while in RUN.
- `done` output, 1: one-cycle pulse when a countdown reaches zero.
- `ovf` output, 1: one-cycle pulse when an up-count wraps from maximum to zero.

## Operation
- Digit radices are fixed by index:
  - d0 = hundredths (10), d1 = tenths (10), d2 = seconds units (10), d3 = seconds tens (6), d4 = minutes units (10), d5 = minutes tens (6).
  - Maximum count is the per-digit value radix−1, e.g. 0x5999 for NUM_DIGITS=4.
- FSM has two states: STOP and RUN.
  - STOP→RUN on `start_stop`, unless down mode is selected and all digits are zero (start ignored). The direction register latches `mode` and the prescaler resets to 0.
  - RUN→STOP on `start_stop`, on `clear`, or when a countdown reaches zero.
- Prescaler counts 0..TICK_DIV−1 only in RUN. A tick fires in the cycle the prescaler equals TICK_DIV−1, after which the prescaler returns to 0.
- Up tick:
  - d0 increments; any digit at radix−1 wraps to 0 and carries into the next digit.
  - All digits at max → all digits become 0, `ovf` pulses, counter keeps running.
- Down tick:
  - d0 decrements; any digit at 0 becomes radix−1 and borrows from the next digit.
  - When the result is all-zero → `done` pulses in the same cycle `time_bcd` shows zero, `running` drops, FSM → STOP.
- `load` is accepted only in STOP and ignored in RUN. Each digit ≥ its radix is clamped to radix−1, e.g. load 0x7A00 with NUM_DIGITS=4 gives 0x5900.
- Priority within one cycle: `clear` > `start_stop` > `load` > tick.
  - `clear` together with `start_stop` → STOP, digits 0.
- `RST` high: all state clears immediately, without waiting for a clock edge. Applies mid-count as well.

## Timing
- Reset values: `time_bcd`=0, `running`=0, `done`=0, `ovf`=0, prescaler=0, FSM=STOP.
- All outputs are registered, with no combinational path from inputs.
- `start_stop` at edge N → `running` high after edge N. The first digit change occurs after edge N+TICK_DIV.
- `load` and `clear` update `time_bcd` one edge after the pulse.
- `done` and `ovf` are high for exactly one cycle, aligned with the `time_bcd` update that caused them.
- Stop then restart: the prescaler restarts from 0, so partial tick time is discarded.

## Configuration
- `CHRONO_LAP_EN` defined:
  - Adds input `lap` (1 bit) and output `lap_bcd` (4*NUM_DIGITS bits, reset 0).
  - A `lap` pulse in RUN copies the post-edge value of `time_bcd` into `lap_bcd` on the same edge.
  - `lap` is ignored in STOP.
  - `clear` also zeroes `lap_bcd`.
- `CHRONO_LAP_EN` undefined: both ports and the lap register are absent. All other behaviour is identical.

## Test plan
All scenarios use TICK_DIV=4, NUM_DIGITS=4.
- Up count: mode=0, start; 400 cycles later `time_bcd`=0x0100, `running`=1, no `ovf`.
- Up wrap: load 0x5999, mode=0, start; 4 cycles later `time_bcd`=0x0000, `ovf` pulses for one cycle, `running` stays 1.
- Countdown with borrow: load 0x1000, mode=1, start; first tick gives 0x0999.
- Countdown completion: load 0x0002, mode=1, start; tick 1 gives 0x0001, tick 2 gives 0x0000 with `done` for one cycle, then `running`=0. A further `start_stop` is ignored.
- Priority and guards:
  - `clear`+`load` in the same cycle → 0x0000.
  - `load` in RUN is ignored.
  - Load 0xFFFF → 0x5999.
  - `RST` pulse mid-run drops all outputs to 0 before the next clock edge.
- Lap (`CHRONO_LAP_EN` defined): `lap` at 0x0037 → `lap_bcd`=0x0037 while `time_bcd` keeps counting; `clear` zeroes both.

Source files
------------

// File: rtl/chrono_counter.sv
// BCD chronometer core: prescaled tick driving a mixed-radix up/down digit chain.
// Optional lap capture register enabled by defining CHRONO_LAP_EN.
module chrono_counter #(
   parameter int unsigned TICK_DIV   = 500000,
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    start_stop,
   input  logic                    clear,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_bcd,
   input  logic                    mode,
`ifdef CHRONO_LAP_EN
   input  logic                    lap,
   output logic [4*NUM_DIGITS-1:0] lap_bcd,
`endif
   output logic [4*NUM_DIGITS-1:0] time_bcd,
   output logic                    running,
   output logic                    done,
   output logic                    ovf
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam int unsigned DW = 4 * NUM_DIGITS;

   typedef enum logic {ST_STOP, ST_RUN} state_t;

   state_t          state_q, state_d;
   logic            dir_q, dir_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [DW-1:0]   digits_q, digits_d;
   logic            done_q, done_d;
   logic            ovf_q, ovf_d;

   logic [DW-1:0]   up_val, dn_val, ld_val;
   logic            up_wrap, carry, borrow, tick;

   // Seconds-tens and minutes-tens digits are base 6; all others base 10.
   function automatic logic [3:0] dig_max(input int unsigned idx);
      return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
   endfunction

   always_comb begin
      up_val = '0;
      dn_val = '0;
      ld_val = '0;
      carry  = 1'b1;
      borrow = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (digits_q[4*i +: 4] == dig_max(i)) begin
               up_val[4*i +: 4] = 4'd0;
            end else begin
               up_val[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end else begin
            up_val[4*i +: 4] = digits_q[4*i +: 4];
         end
         if (borrow) begin
            if (digits_q[4*i +: 4] == 4'd0) begin
               dn_val[4*i +: 4] = dig_max(i);
            end else begin
               dn_val[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end else begin
            dn_val[4*i +: 4] = digits_q[4*i +: 4];
         end
         ld_val[4*i +: 4] = (load_bcd[4*i +: 4] > dig_max(i)) ? dig_max(i)
                                                               : load_bcd[4*i +: 4];
      end
      up_wrap = carry;
   end

   assign tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

   // Priority: clear > start_stop > load > tick.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      presc_d  = presc_q;
      digits_d = digits_q;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
      if (clear) begin
         state_d  = ST_STOP;
         digits_d = '0;
         presc_d  = '0;
      end else if (start_stop) begin
         presc_d = '0;
         if (state_q == ST_RUN) begin
            state_d = ST_STOP;
         end else if (!(mode && (digits_q == '0))) begin
            state_d = ST_RUN;
            dir_d   = mode;
         end
      end else if (load && (state_q == ST_STOP)) begin
         digits_d = ld_val;
      end else if (state_q == ST_RUN) begin
         if (tick) begin
            presc_d = '0;
            if (dir_q) begin
               digits_d = dn_val;
               if (dn_val == '0) begin
                  done_d  = 1'b1;
                  state_d = ST_STOP;
               end
            end else begin
               digits_d = up_val;
               ovf_d    = up_wrap;
            end
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

`ifdef CHRONO_LAP_EN
   logic [DW-1:0] lap_q, lap_d;

   always_comb begin
      lap_d = lap_q;
      if (clear) begin
         lap_d = '0;
      end else if (lap && (state_q == ST_RUN)) begin
         lap_d = digits_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) lap_q <= '0;
      else     lap_q <= lap_d;
   end

   assign lap_bcd = lap_q;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_STOP;
         dir_q    <= 1'b0;
         presc_q  <= '0;
         digits_q <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         presc_q  <= presc_d;
         digits_q <= digits_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   assign time_bcd = digits_q;
   assign running  = (state_q == ST_RUN);
   assign done     = done_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_chrono_counter.sv
// Self-checking bench for chrono_counter (TICK_DIV=4, NUM_DIGITS=4): vector table
// plus hand sequences for async reset and (when CHRONO_LAP_EN is defined) lap capture.
module tb_chrono_counter;

   localparam int unsigned TD = 4;
   localparam int unsigned ND = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          start_stop = 1'b0;
   logic          clear = 1'b0;
   logic          load = 1'b0;
   logic [15:0]   load_bcd = '0;
   logic          mode = 1'b0;
   logic [15:0]   time_bcd;
   logic          running, done, ovf;
`ifdef CHRONO_LAP_EN
   logic          lap = 1'b0;
   logic [15:0]   lap_bcd;
`endif

   chrono_counter #(.TICK_DIV(TD), .NUM_DIGITS(ND)) dut (
      .CLK(CLK), .RST(RST), .start_stop(start_stop), .clear(clear),
      .load(load), .load_bcd(load_bcd), .mode(mode),
`ifdef CHRONO_LAP_EN
      .lap(lap), .lap_bcd(lap_bcd),
`endif
      .time_bcd(time_bcd), .running(running), .done(done), .ovf(ovf)
   );

   always #5 CLK = ~CLK;

   typedef enum {OP_IDLE, OP_LOAD, OP_START, OP_CLEAR, OP_CLRLOAD} op_e;
   typedef struct {
      op_e         op;
      logic [15:0] din;
      logic        md;
      int unsigned w;
      logic [15:0] et;
      logic        er, ed, eo;
   } vec_t;
   typedef struct {
      int          id;
      logic [15:0] t;
      logic        r, d, o;
   } exp_t;

   vec_t vq[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic vec_t mk(op_e op, logic [15:0] din, logic md, int unsigned w,
                               logic [15:0] et, logic er, logic ed, logic eo);
      vec_t v;
      v.op = op; v.din = din; v.md = md; v.w = w;
      v.et = et; v.er = er; v.ed = ed; v.eo = eo;
      return v;
   endfunction

   task automatic push_exp(int id, logic [15:0] t, logic r, logic d, logic o);
      exp_t e;
      e.id = id; e.t = t; e.r = r; e.d = d; e.o = o;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard_empty got 0 entries required 1");
         return;
      end
      e = sb.pop_front();
      n_cmp++;
      if (time_bcd !== e.t) begin
         n_err++; $display("FAIL vec%0d time_bcd got %h required %h", e.id, time_bcd, e.t);
      end
      n_cmp++;
      if (running !== e.r) begin
         n_err++; $display("FAIL vec%0d running got %b required %b", e.id, running, e.r);
      end
      n_cmp++;
      if (done !== e.d) begin
         n_err++; $display("FAIL vec%0d done got %b required %b", e.id, done, e.d);
      end
      n_cmp++;
      if (ovf !== e.o) begin
         n_err++; $display("FAIL vec%0d ovf got %b required %b", e.id, ovf, e.o);
      end
   endtask

   // Pulses are raised at a falling edge and dropped at the next one, so exactly one
   // rising edge sees them; checks happen at falling edges after the wait.
   task automatic apply(int id, vec_t v);
      mode = v.md;
      if (v.op != OP_IDLE) begin
         case (v.op)
            OP_LOAD:    begin load = 1'b1; load_bcd = v.din; end
            OP_START:   start_stop = 1'b1;
            OP_CLEAR:   clear = 1'b1;
            OP_CLRLOAD: begin clear = 1'b1; load = 1'b1; load_bcd = v.din; end
            default:    ;
         endcase
         @(negedge CLK);
         load = 1'b0; start_stop = 1'b0; clear = 1'b0;
      end
      repeat (v.w) @(negedge CLK);
      push_exp(id, v.et, v.er, v.ed, v.eo);
      check_out();
   endtask

   initial begin
      // Load clamping and clear priority
      vq.push_back(mk(OP_LOAD,    16'h7A00, 0, 0, 16'h5900, 0, 0, 0));
      vq.push_back(mk(OP_LOAD,    16'hFFFF, 0, 0, 16'h5999, 0, 0, 0));
      vq.push_back(mk(OP_CLRLOAD, 16'h1234, 0, 0, 16'h0000, 0, 0, 0));
      // Countdown borrow, load ignored in RUN, stop
      vq.push_back(mk(OP_LOAD,    16'h1000, 0, 0, 16'h1000, 0, 0, 0));
      vq.push_back(mk(OP_START,   16'h0,    1, 0, 16'h1000, 1, 0, 0));
      vq.push_back(mk(OP_IDLE,    16'h0,    1, 3, 16'h1000, 1, 0, 0));
      vq.push_back(mk(OP_IDLE,    16'h0,    1, 1, 16'h0999, 1, 0, 0));
      vq.push_back(mk(OP_LOAD,    16'h0500, 1, 0, 16'h0999, 1, 0, 0));
      vq.push_back(mk(OP_START,   16'h0,    0, 0, 16'h0999, 0, 0, 0));
      vq.push_back(mk(OP_CLEAR,   16'h0,    0, 0, 16'h0000, 0, 0, 0));
      vq.push_back(mk(OP_START,   16'h0,    1, 0, 16'h0000, 0, 0, 0));
      // Countdown completion
      vq.push_back(mk(OP_LOAD,    16'h0002, 1, 0, 16'h0002, 0, 0, 0));
      vq.push_back(mk(OP_START,   16'h0,    1, 3, 16'h0002, 1, 0, 0));
      vq.push_back(mk(OP_IDLE,    16'h0,    1, 1, 16'h0001, 1, 0, 0));
      vq.push_back(mk(OP_IDLE,    16'h0,    1, 3, 16'h0001, 1, 0, 0));
      vq.push_back(mk(OP_IDLE,    16'h0,    1, 1, 16'h0000, 0, 1, 0));
      vq.push_back(mk(OP_IDLE,    16'h0,    1, 1, 16'h0000, 0, 0, 0));
      vq.push_back(mk(OP_START,   16'h0,    1, 0, 16'h0000, 0, 0, 0));
      // Up wrap; mode changes while running must not affect direction
      vq.push_back(mk(OP_LOAD,    16'h5999, 0, 0, 16'h5999, 0, 0, 0));
      vq.push_back(mk(OP_START,   16'h0,    0, 3, 16'h5999, 1, 0, 0));
      vq.push_back(mk(OP_IDLE,    16'h0,    1, 1, 16'h0000, 1, 0, 1));
      vq.push_back(mk(OP_IDLE,    16'h0,    1, 1, 16'h0000, 1, 0, 0));
      vq.push_back(mk(OP_CLEAR,   16'h0,    0, 0, 16'h0000, 0, 0, 0));
      // Long up count, then restart discarding partial tick time
      vq.push_back(mk(OP_START,   16'h0,    0, 400, 16'h0100, 1, 0, 0));
      vq.push_back(mk(OP_START,   16'h0,    0, 0, 16'h0100, 0, 0, 0));
      vq.push_back(mk(OP_START,   16'h0,    0, 2, 16'h0100, 1, 0, 0));
      vq.push_back(mk(OP_START,   16'h0,    0, 0, 16'h0100, 0, 0, 0));
      vq.push_back(mk(OP_START,   16'h0,    0, 3, 16'h0100, 1, 0, 0));
      vq.push_back(mk(OP_IDLE,    16'h0,    0, 1, 16'h0101, 1, 0, 0));
      vq.push_back(mk(OP_CLEAR,   16'h0,    0, 0, 16'h0000, 0, 0, 0));

      // Reset state
      repeat (2) @(negedge CLK);
      push_exp(-1, 16'h0000, 0, 0, 0);
      check_out();
      RST = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

      // Asynchronous reset mid-run: outputs clear before any further clock edge
      apply(100, mk(OP_START, 16'h0, 0, 20, 16'h0005, 1, 0, 0));
      #2 RST = 1'b1;
      #1;
      push_exp(101, 16'h0000, 0, 0, 0);
      check_out();
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      push_exp(102, 16'h0000, 0, 0, 0);
      check_out();

`ifdef CHRONO_LAP_EN
      apply(200, mk(OP_START, 16'h0, 0, 147, 16'h0036, 1, 0, 0));
      lap = 1'b1;
      @(negedge CLK);
      lap = 1'b0;
      push_exp(201, 16'h0037, 1, 0, 0);
      check_out();
      n_cmp++;
      if (lap_bcd !== 16'h0037) begin
         n_err++; $display("FAIL lap_capture lap_bcd got %h required 0037", lap_bcd);
      end
      apply(202, mk(OP_IDLE, 16'h0, 0, 4, 16'h0038, 1, 0, 0));
      n_cmp++;
      if (lap_bcd !== 16'h0037) begin
         n_err++; $display("FAIL lap_hold lap_bcd got %h required 0037", lap_bcd);
      end
      apply(203, mk(OP_CLEAR, 16'h0, 0, 0, 16'h0000, 0, 0, 0));
      n_cmp++;
      if (lap_bcd !== 16'h0000) begin
         n_err++; $display("FAIL lap_clear lap_bcd got %h required 0000", lap_bcd);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
